// File: rtl/rc_channel_filter_decoder.sv
// Per-channel RC pulse decoder: centring, polarity, moving-average filter,
// tri-state deadzone/hysteresis decode and signal-loss watchdog with failsafe.
module rc_channel_filter_decoder #(
  parameter int K_NCHAN    = 4,
  parameter int K_RES      = 10,
  parameter int K_AVG_LOG2 = 2,
  parameter int K_TO_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_timebase,
  input  logic [K_NCHAN-1:0]         i_cap_done,
  input  logic [K_NCHAN*K_RES-1:0]   i_cap_value,
  input  logic [K_NCHAN-1:0]         i_polarity,
  input  logic [K_RES-2:0]           i_deadzone,
  input  logic [K_RES-2:0]           i_hyst,
  input  logic [K_TO_WIDTH-1:0]      i_timeout,
  output logic [K_NCHAN*K_RES-1:0]   o_analog,
  output logic [K_NCHAN-1:0]         o_dig_pos,
  output logic [K_NCHAN-1:0]         o_dig_neg,
  output logic [K_NCHAN-1:0]         o_valid,
  output logic [K_NCHAN-1:0]         o_update,
  output logic [K_NCHAN-1:0]         o_lost,
  output logic                       o_failsafe
);

  localparam int D  = 1 << K_AVG_LOG2;
  localparam int SW = K_RES + K_AVG_LOG2;
  localparam int PW = (K_AVG_LOG2 > 0) ? K_AVG_LOG2 : 1;
  localparam int FW = K_AVG_LOG2 + 1;
  localparam logic signed [K_RES-1:0] MAXV = {1'b0, {(K_RES-1){1'b1}}};
  localparam logic signed [K_RES-1:0] MINV = {1'b1, {(K_RES-1){1'b0}}};

  typedef enum logic [1:0] {ST_NEUTRAL, ST_POS, ST_NEG} state_t;

  logic [K_RES-1:0] w_tsum;
  logic [K_RES-2:0] w_thresh;
  logic             r_failsafe;

  always_comb begin
    w_tsum   = {1'b0, i_deadzone} + {1'b0, i_hyst};
    w_thresh = w_tsum[K_RES-1] ? '1 : w_tsum[K_RES-2:0];
  end

  for (genvar g = 0; g < K_NCHAN; g++) begin : g_ch
    logic signed [K_RES-1:0]  w_raw, w_c, w_f;
    logic signed [K_RES-1:0]  r_buf [D];
    logic signed [SW-1:0]     r_sum, w_sum_nxt;
    logic [PW-1:0]            r_ptr, w_ptr_nxt;
    logic [FW-1:0]            r_fill, w_fill_nxt;
    logic [K_TO_WIDTH-1:0]    r_cnt;
    logic [K_RES-2:0]         w_mag;
    logic                     w_pos_entry, w_neg_entry, w_expire;
    state_t                   r_state, w_state_nxt;
    logic signed [K_RES-1:0]  r_analog;
    logic                     r_valid, r_update, r_lost;

    always_comb begin
      w_raw = {~i_cap_value[g*K_RES+K_RES-1], i_cap_value[g*K_RES +: K_RES-1]};
      if (i_polarity[g]) w_c = (w_raw == MINV) ? MAXV : -w_raw;
      else               w_c = w_raw;

      w_sum_nxt = r_sum - SW'(r_buf[r_ptr]) + SW'(w_c);
      w_f       = K_RES'(w_sum_nxt >>> K_AVG_LOG2);
      if (w_f == MINV)          w_mag = '1;
      else if (w_f[K_RES-1])    w_mag = (K_RES-1)'(-w_f);
      else                      w_mag = w_f[K_RES-2:0];

      w_pos_entry = !w_f[K_RES-1] && (w_f != '0) && (w_mag >= w_thresh);
      w_neg_entry =  w_f[K_RES-1] && (w_mag >= w_thresh);

      w_state_nxt = r_state;
      case (r_state)
        ST_NEUTRAL: if (w_pos_entry) w_state_nxt = ST_POS;
                    else if (w_neg_entry) w_state_nxt = ST_NEG;
        ST_POS:     if (w_neg_entry) w_state_nxt = ST_NEG;
                    else if (w_f[K_RES-1] || (w_f == '0) || (w_mag < i_deadzone))
                      w_state_nxt = ST_NEUTRAL;
        ST_NEG:     if (w_pos_entry) w_state_nxt = ST_POS;
                    else if (!w_f[K_RES-1] || (w_mag < i_deadzone))
                      w_state_nxt = ST_NEUTRAL;
        default:    w_state_nxt = ST_NEUTRAL;
      endcase

      w_ptr_nxt  = (r_ptr == PW'(D-1)) ? '0 : r_ptr + 1'b1;
      w_fill_nxt = (r_fill == FW'(D)) ? r_fill : r_fill + 1'b1;
      // A capture in the same cycle always wins over expiry.
      w_expire   = (i_timeout != '0) && (r_cnt >= i_timeout) && !i_cap_done[g];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int unsigned i = 0; i < D; i++) r_buf[i] <= '0;
        r_sum    <= '0;
        r_ptr    <= '0;
        r_fill   <= '0;
        r_cnt    <= '0;
        r_state  <= ST_NEUTRAL;
        r_analog <= '0;
        r_valid  <= 1'b0;
        r_update <= 1'b0;
        r_lost   <= 1'b1;
      end else begin
        r_update <= 1'b0;
        if (i_cap_done[g])                   r_cnt <= '0;
        else if (i_timebase && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;

        if (i_cap_done[g]) begin
          r_buf[r_ptr] <= w_c;
          r_sum        <= w_sum_nxt;
          r_ptr        <= w_ptr_nxt;
          r_fill       <= w_fill_nxt;
          r_analog     <= w_f;
          r_state      <= w_state_nxt;
          r_valid      <= (w_fill_nxt == FW'(D));
          r_update     <= 1'b1;
          r_lost       <= 1'b0;
        end else if (w_expire) begin
          for (int unsigned i = 0; i < D; i++) r_buf[i] <= '0;
          r_sum    <= '0;
          r_ptr    <= '0;
          r_fill   <= '0;
          r_analog <= '0;
          r_state  <= ST_NEUTRAL;
          r_valid  <= 1'b0;
          r_lost   <= 1'b1;
        end
      end
    end

    assign o_analog[g*K_RES +: K_RES] = r_analog;
    assign o_dig_pos[g] = (r_state == ST_POS) && r_valid;
    assign o_dig_neg[g] = (r_state == ST_NEG) && r_valid;
    assign o_valid[g]   = r_valid;
    assign o_update[g]  = r_update;
    assign o_lost[g]    = r_lost;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_failsafe <= 1'b1;
    else          r_failsafe <= |o_lost;
  end

  assign o_failsafe = r_failsafe;

endmodule
